drum_timing: RTL and testbench

//  Drum timing generator: divides clk into bit times and counts bit-in-word (T0..T28) and word-in-line (0..107).

---
 rtl/g15_pkg.sv | 11 +
 rtl/drum_timing_bit_clk_div.sv | 26 ++
 rtl/drum_timing.sv | 105 ++++++++++
 tb/tb_drum_timing.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/g15_pkg.sv
// Shared drum-timing constants and types: word/line geometry, counter types, run/hold states.
package g15_pkg;
    localparam int BITS_PER_WORD    = 29;
    localparam int WORDS_PER_LINE   = 108;
    localparam int SHORT_LINE_WORDS = 4;

    typedef logic [4:0] bit_t;
    typedef logic [6:0] word_t;

    typedef enum logic [1:0] {RUN, DRAIN, HELD, STEP} run_state_e;
endpackage

// File: rtl/drum_timing_bit_clk_div.sv
// Bit-time divider: counts clk cycles within a bit time and strobes on the last one.
module bit_clk_div
    import g15_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // en is itself a registered-state decode, so tick stays free of input paths
    assign tick = en && (cnt == LAST);
endmodule

// File: rtl/drum_timing.sv
// Drum timing generator: bit-time/word-time counters, end-of-word and end-of-revolution
// strobes, debug hold/single-step and a resync-to-origin request.
module drum_timing
    import g15_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       step,
    input  logic       resync,
    output logic       bit_tick,
    output logic [4:0] bit_ctr,
    output logic [6:0] word_ctr,
    output logic [1:0] short_wd,
    output logic       odd_word,
    output logic       t0,
    output logic       t28,
    output logic       word_tick,
    output logic       rev_tick,
    output logic       held
);
    localparam bit_t  BIT_LAST  = bit_t'(BITS_PER_WORD - 1);
    localparam word_t WORD_LAST = word_t'(WORDS_PER_LINE - 1);

    run_state_e state, state_nx;
    logic       run_en;
    logic       pend;
    logic       word_end;
    bit_t       bit_q;
    word_t      word_q;

    bit_clk_div #(.DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .tick (bit_tick)
    );

    assign bit_ctr  = bit_q;
    assign word_ctr = word_q;
    assign short_wd = word_q[1:0];
    assign odd_word = word_q[0];
    assign t0       = (bit_q == '0);
    assign t28      = (bit_q == BIT_LAST);

    // A pending resync turns the end-of-word tick into a load of the origin
    assign word_end  = bit_tick && t28 && !pend;
    assign word_tick = word_end;
    assign rev_tick  = word_end && (word_q == WORD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:   if (hold) state_nx = word_end ? HELD : DRAIN;
            DRAIN: if (!hold) state_nx = RUN;
                   else if (word_end) state_nx = HELD;
            HELD:  if (!hold) state_nx = RUN;
                   else if (step) state_nx = STEP;
            STEP:  if (!hold) state_nx = RUN;
                   else if (word_end) state_nx = HELD;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        held   = (state == HELD);
        run_en = (state != HELD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q  <= '0;
            word_q <= '0;
        end else if (bit_tick) begin
            if (pend) begin
                bit_q  <= '0;
                word_q <= '0;
            end else if (t28) begin
                bit_q  <= '0;
                word_q <= (word_q == WORD_LAST) ? '0 : word_q + 1'b1;
            end else begin
                bit_q  <= bit_q + 1'b1;
            end
        end
    end

    // No ticks while HELD, so a resync raised there waits for counting to resume
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend <= 1'b0;
        else if (resync)
            pend <= 1'b1;
        else if (bit_tick)
            pend <= 1'b0;
    end
endmodule

// File: tb/tb_drum_timing.sv
// Randomised scoreboard bench for drum_timing against a drum-position reference model.
module tb_drum_timing;
    localparam int D    = 4;
    localparam int NPOS = 29 * 108;

    logic       clk = 1'b0, rst = 1'b1, hold = 1'b0, step = 1'b0, resync = 1'b0;
    logic       bit_tick, odd_word, t0, t28, word_tick, rev_tick, held;
    logic [4:0] bit_ctr;
    logic [6:0] word_ctr;
    logic [1:0] short_wd;

    always #5 clk = ~clk;

    drum_timing #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .hold(hold), .step(step), .resync(resync),
        .bit_tick(bit_tick), .bit_ctr(bit_ctr), .word_ctr(word_ctr), .short_wd(short_wd),
        .odd_word(odd_word), .t0(t0), .t28(t28), .word_tick(word_tick),
        .rev_tick(rev_tick), .held(held)
    );

    typedef struct packed {
        logic       bt;
        logic [4:0] b;
        logic [6:0] w;
        logic [1:0] sw;
        logic       ow, t0, t28, wt, rt, hd;
    } obs_t;
    typedef struct { obs_t o; int idx; } ent_t;

    localparam obs_t RST_OBS = '{bt:1'b0, b:5'd0, w:7'd0, sw:2'd0, ow:1'b0, t0:1'b1,
                                 t28:1'b0, wt:1'b0, rt:1'b0, hd:1'b0};

    obs_t act;
    always_comb act = {bit_tick, bit_ctr, word_ctr, short_wd, odd_word, t0, t28,
                       word_tick, rev_tick, held};

    ent_t q[$];
    int vectors = 0, fails = 0, cyc = 0;
    int bt_cnt = 0, wt_cnt = 0, rt_cnt = 0, first_bt = -1, first_rt = -1;

    // Reference: drum position as one linear index plus clk phase inside the bit time
    int m_phase, m_pos, m_mode;  // mode 0 run, 1 drain, 2 held, 3 step
    bit m_pend;

    function automatic obs_t expect_now();
        obs_t e;
        int b, w;
        b      = m_pos % 29;
        w      = m_pos / 29;
        e.hd   = (m_mode == 2);
        e.bt   = (m_phase == D - 1) && !e.hd;
        e.b    = 5'(b);
        e.w    = 7'(w);
        e.sw   = 2'(w % 4);
        e.ow   = (w % 2) == 1;
        e.t0   = (b == 0);
        e.t28  = (b == 28);
        e.wt   = e.bt && e.t28 && !m_pend;
        e.rt   = e.wt && (w == 107);
        return e;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_mode = 0; m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit h, input bit s, input bit r);
        obs_t e;
        e = expect_now();
        case (m_mode)
            0: if (h) m_mode = e.wt ? 2 : 1;
            1: if (!h) m_mode = 0; else if (e.wt) m_mode = 2;
            2: if (!h) m_mode = 0; else if (s) m_mode = 3;
            default: if (!h) m_mode = 0; else if (e.wt) m_mode = 2;
        endcase
        if (!e.hd) m_phase = (m_phase + 1) % D;
        if (e.bt) begin
            m_pos  = m_pend ? 0 : (m_pos + 1) % NPOS;
            m_pend = 1'b0;
        end
        if (r) m_pend = 1'b1;
    endtask

    task automatic push_exp();
        ent_t e;
        e.o   = expect_now();
        e.idx = cyc;
        q.push_back(e);
    endtask

    // Advance one clk: model consumes the inputs the DUT sampled, pulses drop, expectation queued
    task automatic cycle();
        @(posedge clk);
        model_edge(hold, step, resync);
        #1;
        step = 1'b0; resync = 1'b0;
        cyc++;
        push_exp();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        fails++;
        $display("FAIL %s timed out", nm);
    endtask

    task automatic monitor();
        ent_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (act !== e.o) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got=%h want=%h", e.idx, act, e.o);
                end
                if (act.bt) begin bt_cnt++; if (first_bt < 0) first_bt = e.idx; end
                if (act.wt) wt_cnt++;
                if (act.rt) begin rt_cnt++; if (first_rt < 0) first_rt = e.idx; end
            end
        end
    endtask

    task automatic wait_pos(input int target, input string nm);
        int n = 0;
        hold = 1'b0;
        while (!(m_pos == target && m_phase == 0 && m_mode == 0) && n < 20000) begin
            cycle(); n++;
        end
        if (n >= 20000) timeout(nm);
    endtask

    task automatic wait_bit10(input string nm);
        int n = 0;
        hold = 1'b0;
        while (!(m_pos % 29 == 10 && m_phase == 0 && m_mode == 0) && n < 400) begin
            cycle(); n++;
        end
        if (n >= 400) timeout(nm);
    endtask

    initial begin
        int tw, bt0, wt0, rt0, n;
        bit h;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cyc = 1;
        push_exp();

        // One full revolution from reset
        repeat (12540) cycle();
        settle();
        check("first_bit_tick_clk", first_bt, 4);
        check("word_ticks_per_rev", wt_cnt, 108);
        check("rev_ticks", rt_cnt, 1);
        check("first_rev_tick_clk", first_rt, 12528);

        // resync mid-word
        wait_pos(50 * 29 + 3, "wait_w50_b3");
        wt0 = wt_cnt;
        resync = 1'b1;
        repeat (4) cycle();
        check("resync_mid_ctr", {word_ctr, bit_ctr}, 0);
        settle();
        check("resync_mid_no_wt", wt_cnt, wt0);

        // resync landing on the end-of-revolution tick
        wait_pos(NPOS - 1, "wait_w107_t28");
        wt0 = wt_cnt; rt0 = rt_cnt;
        resync = 1'b1;
        repeat (4) cycle();
        check("resync_wrap_ctr", {word_ctr, bit_ctr}, 0);
        settle();
        check("resync_wrap_no_rt", rt_cnt, rt0);
        check("resync_wrap_no_wt", wt_cnt, wt0);

        // Hold mid-word, freeze, single step, release
        wait_bit10("wait_bit10_hold");
        tw = m_pos / 29;
        hold = 1'b1;
        n = 0;
        while (m_mode != 2 && n < 200) begin cycle(); n++; end
        if (n >= 200) timeout("drain_to_held");
        settle();
        check("held_after_drain", held, 1);
        check("held_word", word_ctr, (tw + 1) % 108);
        check("held_bit", bit_ctr, 0);
        bt0 = bt_cnt; wt0 = wt_cnt;
        repeat (1000) cycle();
        settle();
        check("frozen_bit_ticks", bt_cnt - bt0, 0);
        check("frozen_word", word_ctr, (tw + 1) % 108);
        step = 1'b1;
        repeat (120) cycle();
        settle();
        check("step_bit_ticks", bt_cnt - bt0, 29);
        check("step_word_ticks", wt_cnt - wt0, 1);
        check("step_reheld", held, 1);
        check("step_word", word_ctr, (tw + 2) % 108);
        hold = 1'b0;
        repeat (50) cycle();

        // Random hold/step/resync traffic
        h = 1'b0;
        repeat (25000) begin
            if ($urandom_range(0, 399) == 0) h = !h;
            hold   = h;
            step   = ($urandom_range(0, 39) == 0);
            resync = ($urandom_range(0, 249) == 0);
            cycle();
        end

        // Async reset while draining toward a hold
        wait_bit10("wait_bit10_reset");
        hold = 1'b1;
        repeat (8) cycle();
        check("in_drain_before_reset", m_mode, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", int'(act), int'(RST_OBS));
        repeat (2) @(posedge clk);
        hold = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        cyc = 1;
        push_exp();
        repeat (300) cycle();
        settle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
